// File: rtl/store_buffer.sv
// Committed-store buffer: in-order circular FIFO that merges into the youngest
// pending entry, issues dcache write requests in order and forwards to loads.
module store_buffer #(
    parameter int SBUF_LEN = 4,
    parameter int SBUF_WTH = $clog2(SBUF_LEN)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [31:0]         st_paddr_i,
    input  logic [63:0]         st_data_i,
    input  logic [7:0]          st_be_i,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [31:0]         req_paddr_o,
    output logic [63:0]         req_data_o,
    output logic [7:0]          req_be_o,
    output logic [SBUF_WTH-1:0] req_idx_o,
    input  logic                rsp_valid_i,
    input  logic [SBUF_WTH-1:0] rsp_idx_i,
    input  logic [31:0]         ld_paddr_i,
    input  logic [7:0]          ld_be_i,
    output logic [63:0]         fwd_data_o,
    output logic [7:0]          fwd_be_o,
    output logic                fwd_hit_o,
    output logic                fwd_partial_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        ENT_INVALID = 2'd0,
        ENT_PENDING = 2'd1,
        ENT_ISSUED  = 2'd2
    } ent_state_e;

    localparam logic [SBUF_WTH:0] LEN_C = (SBUF_WTH + 1)'(SBUF_LEN);

    ent_state_e          state_q [SBUF_LEN];
    logic [28:0]         addr_q  [SBUF_LEN];
    logic [63:0]         data_q  [SBUF_LEN];
    logic [7:0]          be_q    [SBUF_LEN];

    logic [SBUF_WTH-1:0] head_q;
    logic [SBUF_WTH-1:0] iss_q;
    logic [SBUF_WTH-1:0] tail_q;
    logic [SBUF_WTH:0]   count_q;
    logic                err_q;

    logic [SBUF_WTH-1:0] tail_m1;
    logic                req_fire;
    logic                merge_ok;
    logic                st_fire;
    logic                alloc;
    logic                rsp_ok;
    logic                rsp_err;
    logic [SBUF_WTH-1:0] fidx;
    logic [7:0]          fwd_cov;

    assign tail_m1  = tail_q - 1'b1;

    assign req_valid_o = (state_q[iss_q] == ENT_PENDING);
    assign req_paddr_o = {addr_q[iss_q], 3'b000};
    assign req_data_o  = data_q[iss_q];
    assign req_be_o    = be_q[iss_q];
    assign req_idx_o   = iss_q;
    assign req_fire    = req_valid_o & req_ready_i;

    // Merging is refused when the youngest entry is leaving for the dcache this
    // cycle, so a merged byte can never miss the write it belongs to.
    assign merge_ok = (count_q != '0)
                   && (state_q[tail_m1] == ENT_PENDING)
                   && (addr_q[tail_m1] == st_paddr_i[31:3])
                   && !(req_fire && (iss_q == tail_m1));

    assign st_ready_o = (count_q < LEN_C) || merge_ok;
    assign st_fire    = st_valid_i & st_ready_o;
    assign alloc      = st_fire & ~merge_ok;

    assign rsp_ok  = rsp_valid_i && (rsp_idx_i == head_q) && (state_q[head_q] == ENT_ISSUED);
    assign rsp_err = rsp_valid_i && !rsp_ok;

    // Control state. Alloc, issue and retire always target distinct entries:
    // the tail entry is INVALID, iss is PENDING and head is ISSUED.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SBUF_LEN; i++) begin
                state_q[i] <= ENT_INVALID;
            end
            head_q  <= '0;
            iss_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (alloc) begin
                state_q[tail_q] <= ENT_PENDING;
                tail_q          <= tail_q + 1'b1;
            end
            if (req_fire) begin
                state_q[iss_q] <= ENT_ISSUED;
                iss_q          <= iss_q + 1'b1;
            end
            if (rsp_ok) begin
                state_q[head_q] <= ENT_INVALID;
                head_q          <= head_q + 1'b1;
            end
            if (alloc && !rsp_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!alloc && rsp_ok) begin
                count_q <= count_q - 1'b1;
            end
            err_q <= rsp_err;
        end
    end

    // Entry payload storage carries no reset; state_q alone decides validity.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            addr_q[tail_q] <= st_paddr_i[31:3];
            data_q[tail_q] <= st_data_i;
            be_q[tail_q]   <= st_be_i;
        end else if (st_fire) begin
            for (int b = 0; b < 8; b++) begin
                if (st_be_i[b]) begin
                    data_q[tail_m1][b*8 +: 8] <= st_data_i[b*8 +: 8];
                end
            end
            be_q[tail_m1] <= be_q[tail_m1] | st_be_i;
        end
    end

    // Walk entries oldest to youngest so the youngest matching byte wins.
    always_comb begin
        fwd_be_o   = '0;
        fwd_data_o = '0;
        fidx       = head_q;
        for (int k = 0; k < SBUF_LEN; k++) begin
            fidx = head_q + SBUF_WTH'(k);
            if ((state_q[fidx] != ENT_INVALID) && (addr_q[fidx] == ld_paddr_i[31:3])) begin
                for (int b = 0; b < 8; b++) begin
                    if (be_q[fidx][b]) begin
                        fwd_be_o[b]             = 1'b1;
                        fwd_data_o[b*8 +: 8]    = data_q[fidx][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign fwd_cov       = fwd_be_o & ld_be_i;
    assign fwd_hit_o     = (ld_be_i != 8'h00) && (fwd_cov == ld_be_i);
    assign fwd_partial_o = (fwd_cov != 8'h00) && !fwd_hit_o;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == LEN_C);
    assign err_o   = err_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_store_buffer;

    localparam int LEN = 4;
    localparam int W   = 2;

    logic          clk;
    logic          rst_ni;
    logic          st_valid_i;
    logic          st_ready_o;
    logic [31:0]   st_paddr_i;
    logic [63:0]   st_data_i;
    logic [7:0]    st_be_i;
    logic          req_valid_o;
    logic          req_ready_i;
    logic [31:0]   req_paddr_o;
    logic [63:0]   req_data_o;
    logic [7:0]    req_be_o;
    logic [W-1:0]  req_idx_o;
    logic          rsp_valid_i;
    logic [W-1:0]  rsp_idx_i;
    logic [31:0]   ld_paddr_i;
    logic [7:0]    ld_be_i;
    logic [63:0]   fwd_data_o;
    logic [7:0]    fwd_be_o;
    logic          fwd_hit_o;
    logic          fwd_partial_o;
    logic          empty_o;
    logic          full_o;
    logic          err_o;

    store_buffer #(.SBUF_LEN(LEN), .SBUF_WTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .st_valid_i   (st_valid_i),
        .st_ready_o   (st_ready_o),
        .st_paddr_i   (st_paddr_i),
        .st_data_i    (st_data_i),
        .st_be_i      (st_be_i),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_paddr_o  (req_paddr_o),
        .req_data_o   (req_data_o),
        .req_be_o     (req_be_o),
        .req_idx_o    (req_idx_o),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_idx_i    (rsp_idx_i),
        .ld_paddr_i   (ld_paddr_i),
        .ld_be_i      (ld_be_i),
        .fwd_data_o   (fwd_data_o),
        .fwd_be_o     (fwd_be_o),
        .fwd_hit_o    (fwd_hit_o),
        .fwd_partial_o(fwd_partial_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: live stores in age order, oldest first.
    typedef struct {
        logic [28:0] a;
        logic [63:0] d;
        logic [7:0]  be;
        bit          iss;
        int          idx;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    bit          err_exp;

    int          n, fp, yg;
    bit          rf, mg, rok, st_rdy_e, hit_e, part_e;
    logic [7:0]  fbe;
    logic [63:0] fd, mask;
    ent_t        e;

    always @(negedge clk) begin
        if (!rst_ni) begin
            q.delete();
            m_tail  = 0;
            err_exp = 1'b0;
            chk("rst_empty",    64'(empty_o),       64'd1);
            chk("rst_full",     64'(full_o),        64'd0);
            chk("rst_st_ready", 64'(st_ready_o),    64'd1);
            chk("rst_req_valid",64'(req_valid_o),   64'd0);
            chk("rst_err",      64'(err_o),         64'd0);
            chk("rst_fwd_be",   64'(fwd_be_o),      64'd0);
            chk("rst_fwd_data", fwd_data_o,         64'd0);
            chk("rst_fwd_hit",  64'(fwd_hit_o),     64'd0);
            chk("rst_fwd_part", 64'(fwd_partial_o), 64'd0);
        end else begin
            n  = q.size();
            fp = -1;
            for (int i = n - 1; i >= 0; i--) if (!q[i].iss) fp = i;
            yg = n - 1;
            rf = (fp >= 0) && req_ready_i;
            mg = (n > 0) && !q[yg].iss && (q[yg].a == st_paddr_i[31:3]) && !(rf && fp == yg);
            st_rdy_e = (n < LEN) || mg;

            fbe = '0;
            fd  = '0;
            for (int i = 0; i < n; i++) begin
                if (q[i].a == ld_paddr_i[31:3]) begin
                    for (int b = 0; b < 8; b++) begin
                        if (q[i].be[b]) begin
                            fbe[b]        = 1'b1;
                            fd[b*8 +: 8]  = q[i].d[b*8 +: 8];
                        end
                    end
                end
            end
            hit_e  = (ld_be_i != 0) && ((fbe & ld_be_i) == ld_be_i);
            part_e = ((fbe & ld_be_i) != 0) && !hit_e;

            chk("st_ready",  64'(st_ready_o),    64'(st_rdy_e));
            chk("req_valid", 64'(req_valid_o),   64'(fp >= 0));
            if (fp >= 0) begin
                mask = '0;
                for (int b = 0; b < 8; b++) if (q[fp].be[b]) mask[b*8 +: 8] = 8'hFF;
                chk("req_paddr", 64'(req_paddr_o), 64'({q[fp].a, 3'b000}));
                chk("req_be",    64'(req_be_o),    64'(q[fp].be));
                chk("req_idx",   64'(req_idx_o),   64'(q[fp].idx));
                chk("req_data",  req_data_o & mask, q[fp].d & mask);
            end
            chk("fwd_be",    64'(fwd_be_o),      64'(fbe));
            chk("fwd_data",  fwd_data_o,         fd);
            chk("fwd_hit",   64'(fwd_hit_o),     64'(hit_e));
            chk("fwd_part",  64'(fwd_partial_o), 64'(part_e));
            chk("empty",     64'(empty_o),       64'(n == 0));
            chk("full",      64'(full_o),        64'(n == LEN));
            chk("err",       64'(err_o),         64'(err_exp));

            rok = rsp_valid_i && (n > 0) && q[0].iss && (32'(rsp_idx_i) == q[0].idx);

            if (rf) begin
                e = q[fp]; e.iss = 1'b1; q[fp] = e;
            end
            if (st_valid_i && st_rdy_e) begin
                if (mg) begin
                    e = q[yg];
                    for (int b = 0; b < 8; b++) if (st_be_i[b]) e.d[b*8 +: 8] = st_data_i[b*8 +: 8];
                    e.be = e.be | st_be_i;
                    q[yg] = e;
                end else begin
                    e.a   = st_paddr_i[31:3];
                    e.d   = st_data_i;
                    e.be  = st_be_i;
                    e.iss = 1'b0;
                    e.idx = m_tail;
                    m_tail = (m_tail + 1) % LEN;
                    q.push_back(e);
                end
            end
            if (rok) void'(q.pop_front());
            err_exp = rsp_valid_i && !rok;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        st_valid_i  = 1'b0;
        st_paddr_i  = '0;
        st_data_i   = '0;
        st_be_i     = '0;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_idx_i   = '0;
        ld_paddr_i  = '0;
        ld_be_i     = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle();
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [7:0] be, input logic [63:0] d);
        st_valid_i = 1'b1;
        st_paddr_i = a;
        st_be_i    = be;
        st_data_i  = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        #1;
        step();
        chk("init_empty",    64'(empty_o),    64'd1);
        chk("init_st_ready", 64'(st_ready_o), 64'd1);
        step();
        rst_ni = 1'b1;

        // Merge of two halves of one doubleword
        store(32'h1000, 8'h0F, 64'h0000_0000_1122_3344);
        step();
        store(32'h1004, 8'hF0, 64'hAABB_CCDD_0000_0000);
        #1 chk("merge_ready", 64'(st_ready_o), 64'd1);
        step();
        st_valid_i = 1'b0;
        chk("m_req_valid", 64'(req_valid_o), 64'd1);
        chk("m_req_paddr", 64'(req_paddr_o), 64'h1000);
        chk("m_req_be",    64'(req_be_o),    64'hFF);
        chk("m_req_data",  req_data_o,       64'hAABB_CCDD_1122_3344);
        chk("m_count",     64'(q.size()),    64'd1);
        req_ready_i = 1'b1;
        step();
        req_ready_i = 1'b0;
        chk("m_one_req", 64'(req_valid_o), 64'd0);
        rsp_valid_i = 1'b1;
        rsp_idx_i   = 2'd0;
        step();
        rsp_valid_i = 1'b0;
        chk("m_drained", 64'(empty_o), 64'd1);

        // Fill, reject, merge at full
        do_reset();
        for (int i = 0; i < 4; i++) begin
            store(32'h3000 + 32'(i * 8), 8'hFF, {32'h0, 32'(i)});
            step();
        end
        st_valid_i = 1'b0;
        chk("fill_full", 64'(full_o), 64'd1);
        store(32'h3020, 8'hFF, 64'h5);
        #1 chk("fill_reject", 64'(st_ready_o), 64'd0);
        step();
        store(32'h3018, 8'h01, 64'h77);
        #1 chk("fill_merge", 64'(st_ready_o), 64'd1);
        step();
        st_valid_i = 1'b0;

        // Out-of-order response is an error, in-order one retires
        req_ready_i = 1'b1;
        step();
        step();
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b1;
        rsp_idx_i   = 2'd1;
        step();
        rsp_valid_i = 1'b0;
        chk("bad_rsp_err",  64'(err_o),  64'd1);
        chk("bad_rsp_full", 64'(full_o), 64'd1);
        step();
        chk("err_pulse", 64'(err_o), 64'd0);
        rsp_valid_i = 1'b1;
        rsp_idx_i   = 2'd0;
        step();
        rsp_valid_i = 1'b0;
        chk("rsp_count", 64'(q.size()), 64'd3);
        chk("rsp_full",  64'(full_o),   64'd0);

        // Response and distinct store against a full buffer
        store(32'h4000, 8'hFF, 64'h4444);
        step();
        st_valid_i = 1'b0;
        chk("refill_full", 64'(full_o), 64'd1);
        rsp_valid_i = 1'b1;
        rsp_idx_i   = 2'd1;
        store(32'h5000, 8'hFF, 64'h5555);
        #1 chk("full_rsp_reject", 64'(st_ready_o), 64'd0);
        step();
        rsp_valid_i = 1'b0;
        chk("after_rsp_count", 64'(q.size()),   64'd3);
        chk("after_rsp_ready", 64'(st_ready_o), 64'd1);
        step();
        st_valid_i = 1'b0;
        chk("after_store_full", 64'(full_o), 64'd1);

        // Asynchronous reset with one entry issued
        req_ready_i = 1'b1;
        step();
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b1;
        rsp_idx_i   = 2'd2;
        step();
        rsp_valid_i = 1'b0;
        req_ready_i = 1'b1;
        step();
        req_ready_i = 1'b0;
        chk("pre_rst_count", 64'(q.size()), 64'd3);
        ld_paddr_i = 32'h4000;
        ld_be_i    = 8'hFF;
        #1 chk("pre_rst_fwd", 64'(fwd_be_o), 64'hFF);
        rst_ni = 1'b0;
        #1;
        chk("arst_empty",    64'(empty_o),     64'd1);
        chk("arst_req",      64'(req_valid_o), 64'd0);
        chk("arst_st_ready", 64'(st_ready_o),  64'd1);
        chk("arst_fwd_be",   64'(fwd_be_o),    64'd0);
        chk("arst_fwd_hit",  64'(fwd_hit_o),   64'd0);
        step();
        rst_ni = 1'b1;
        idle();
        store(32'h6000, 8'hFF, 64'h6666);
        step();
        st_valid_i = 1'b0;
        chk("post_rst_idx",   64'(req_idx_o),   64'd0);
        chk("post_rst_paddr", 64'(req_paddr_o), 64'h6000);

        // Forwarding takes the youngest byte
        do_reset();
        store(32'h2000, 8'h01, 64'hAA);
        step();
        st_valid_i  = 1'b0;
        req_ready_i = 1'b1;
        step();
        req_ready_i = 1'b0;
        store(32'h2000, 8'h01, 64'hBB);
        step();
        st_valid_i = 1'b0;
        ld_paddr_i = 32'h2000;
        ld_be_i    = 8'h01;
        #1;
        chk("fwd_hit_lit",  64'(fwd_hit_o),        64'd1);
        chk("fwd_byte_lit", 64'(fwd_data_o[7:0]),  64'hBB);
        ld_be_i = 8'h03;
        store(32'h2000, 8'h02, 64'hCC00);
        #1;
        chk("fwd_part_lit", 64'(fwd_partial_o), 64'd1);
        chk("fwd_no_bypass",64'(fwd_hit_o),     64'd0);
        step();
        st_valid_i = 1'b0;
        #1 chk("fwd_after_merge", 64'(fwd_hit_o), 64'd1);
        step();

        // Random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            st_valid_i  = ($urandom_range(0, 1) == 1);
            st_paddr_i  = 32'h7000 + 32'($urandom_range(0, 3) * 8) + 32'($urandom_range(0, 7));
            st_be_i     = 8'($urandom_range(1, 255));
            st_data_i   = {$urandom, $urandom};
            req_ready_i = ($urandom_range(0, 1) == 1);
            rsp_valid_i = ($urandom_range(0, 9) < 4);
            if (q.size() > 0 && q[0].iss && $urandom_range(0, 9) < 8)
                rsp_idx_i = W'(q[0].idx);
            else
                rsp_idx_i = W'($urandom_range(0, LEN - 1));
            ld_paddr_i  = 32'h7000 + 32'($urandom_range(0, 4) * 8);
            ld_be_i     = 8'($urandom_range(0, 255));
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
